mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single-ported unified instruction/data memory of the RISCV_pipeline datapath between two requesters: the IF stage (fetch port) and the MEM stage (load/store port).
- Serialises accesses through a small FSM, gives priority to data, and bounds fetch starvation.
- Sits between the pipeline stages and the memory block; the pipeline stalls on any port whose request is not yet acknowledged.

Parameters:
- ADDR_W, 32, address width of both ports and memory
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch waits before the fetch is forced

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DATA_W  fetched instruction, valid while if_ack=1
- d_req  in  1  data request; held with d_* fields until d_ack
- d_we  in  1  1=store, 0=load
- d_size  in  3  funct3 width code, passed through to memory
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DATA_W  load data, valid while d_ack=1; 0 for stores
- mem_en  out  1  one-cycle access strobe
- mem_we, mem_size, mem_addr, mem_wdata  out  1/3/ADDR_W/DATA_W  latched access fields
- mem_ready  in  1  memory completion; mem_rdata valid this cycle
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset state:
  - FSM=IDLE, starvation counter=0.
  - All outputs 0: mem_en, mem_we, mem_size, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE arbitration:
  - If if_req and counter==STARVE_MAX, grant fetch.
  - Else if d_req, grant data.
  - Else if if_req, grant fetch.
  - Else stay in IDLE.
  - On a grant: latch owner and that port's fields, go to ISSUE.
  - A fetch grant uses mem_we=0 and mem_size=3'b010.
- ISSUE: mem_en=1 for exactly this cycle with the latched fields. Go to WAIT unconditionally; mem_ready in ISSUE is ignored.
- WAIT: mem_en=0. When mem_ready=1, capture mem_rdata (or 0 if the latched we=1) into the owner's rdata register and go to RESP. There is no timeout; WAIT holds indefinitely.
- RESP: owner's ack=1 for this one cycle, other ack=0. Go to IDLE.
  - Requesters sample ack at the RESP-ending edge and deassert req there, so IDLE never re-sees a finished request.
  - Back-to-back accesses start from the next IDLE.
- Latency: with a 1-cycle memory (mem_ready in the first WAIT cycle), req seen in IDLE at cycle 0 gives mem_en at cycle 1 and ack at cycle 3. The next grant is at cycle 4, so throughput is one access per 4 cycles.
- if_rdata and d_rdata hold their last value outside ack cycles.
- Starvation counter:
  - On a data grant with if_req=1: increment, saturating at STARVE_MAX.
  - On a fetch grant: clear to 0.
  - On a data grant with if_req=0: clear to 0.
- Simultaneous requests: data wins unless the counter==STARVE_MAX.
- A request arriving while not in IDLE waits; it is never dropped.
- Arbiter performs no alignment or size checks; misaligned addresses pass through.
- Reset mid-operation: next cycle is IDLE with all outputs 0. The in-flight access is abandoned and no ack is issued; a late mem_ready is ignored.
- Requesters must not change fields while req=1 and ack=0. Fields are latched at grant, so later changes do not affect the issued access.

Decomposition:
- Shared package holds:
  - FSM state encoding localparams: IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3
  - owner encoding: OWN_I=1'b0, OWN_D=1'b1
  - fetch size constant: SZ_WORD=3'b010
- One natural sub-module: arb_starve_ctr, the saturating starvation counter with inc/clr inputs and an at_max output.
- The FSM and datapath latches stay in mem_arbiter.

Test Plan:
- Fetch only: rst 2 cycles, then if_req=1 with if_addr=0x00000010, memory returns 0x00500093 with 1-cycle latency.
  - Expect mem_en at cycle 1 with addr 0x10, we=0, size=010.
  - Expect if_ack at cycle 3 with if_rdata=0x00500093, and d_ack=0 throughout.
- Simultaneous requests: if_req and d_req (store, addr 0x100, wdata 0xDEADBEEF, size 010) both asserted in the same cycle.
  - Expect the data access first (mem_we=1, mem_addr=0x100), d_ack with d_rdata=0.
  - Expect the fetch next, with if_ack 4 cycles after d_ack.
- Starvation: if_req held high while d_req is re-asserted immediately after every d_ack.
  - Expect exactly 4 data grants, then a fetch grant, then the counter back at 0 (data granted next).
- Slow memory: load at addr 0x200 with mem_ready delayed 5 cycles.
  - Expect mem_en high for exactly 1 cycle, no ack until mem_ready.
  - Expect d_ack exactly 1 cycle after mem_ready, with d_rdata equal to mem_rdata.
- Reset mid-access: assert rst while in WAIT, then pulse mem_ready.
  - Expect all outputs 0 and the FSM in IDLE the cycle after rst.
  - Expect no ack and no spurious mem_en.
- Field change after grant: change d_addr from 0x300 to 0x304 in ISSUE.
  - Expect mem_addr to stay at 0x300.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the unified-memory arbiter.
// FSM states, owner tags and the fixed fetch width.
package mem_arbiter_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [2:0] SZ_WORD = 3'b010;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch waits.
// at_max_o forces the next grant to the fetch port.
module arb_starve_ctr #(
  parameter int unsigned MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic at_max_o
);

  localparam int unsigned W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max_o = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the single-ported unified memory.
// Data has priority; the starvation counter bounds fetch waits.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [2:0]        d_size_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [2:0]        mem_size_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  logic [1:0]        state_q, state_d;
  logic              own_q, own_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [2:0]        mem_size_q, mem_size_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic in_idle;
  logic at_max;
  logic gnt_i;
  logic gnt_d;
  logic capture;
  logic [DATA_W-1:0] rd_val;

  assign in_idle = (state_q == IDLE);
  assign gnt_i   = in_idle & if_req_i & (at_max | ~d_req_i);
  assign gnt_d   = in_idle & d_req_i & ~gnt_i;
  assign capture = (state_q == WAIT) & mem_ready_i;
  // stores complete with zero read data
  assign rd_val  = mem_we_q ? '0 : mem_rdata_i;

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_ctr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .inc_i    (gnt_d & if_req_i),
    .clr_i    (gnt_i | (gnt_d & ~if_req_i)),
    .at_max_o (at_max)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      own_q       <= OWN_I;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      own_q       <= own_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_i || gnt_d) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_ready_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    own_d       = own_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (1'b1)
      gnt_i: begin
        own_d       = OWN_I;
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b0;
        mem_size_d  = SZ_WORD;
        mem_addr_d  = if_addr_i;
        mem_wdata_d = '0;
      end
      gnt_d: begin
        own_d       = OWN_D;
        mem_en_d    = 1'b1;
        mem_we_d    = d_we_i;
        mem_size_d  = d_size_i;
        mem_addr_d  = d_addr_i;
        mem_wdata_d = d_wdata_i;
      end
      capture: begin
        if (own_q == OWN_D) begin
          d_rdata_d = rd_val;
          d_ack_d   = 1'b1;
        end else begin
          if_rdata_d = rd_val;
          if_ack_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_size_o  = mem_size_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, queued
// expectations, and a monitor comparing every strobe and ack.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i = 1'b0;
  logic        d_we_i = 1'b0;
  logic [2:0]  d_size_i = '0;
  logic [31:0] d_addr_i = '0;
  logic [31:0] d_wdata_i = '0;
  logic        d_ack_o;
  logic [31:0] d_rdata_o;
  logic        mem_en_o;
  logic        mem_we_o;
  logic [2:0]  mem_size_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_ack_o    (if_ack_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_size_i    (d_size_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_ack_o     (d_ack_o),
    .d_rdata_o   (d_rdata_o),
    .mem_en_o    (mem_en_o),
    .mem_we_o    (mem_we_o),
    .mem_size_o  (mem_size_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    logic        port;
    logic [31:0] rdata;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  acc_t ea;
  rsp_t er;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_acc(logic we, logic [2:0] sz, logic [31:0] a,
                          logic [31:0] wd);
    acc_t e;
    e.we = we; e.size = sz; e.addr = a; e.wdata = wd;
    exp_acc.push_back(e);
  endtask

  task automatic push_rsp(logic port, logic [31:0] rd);
    rsp_t r;
    r.port = port; r.rdata = rd;
    exp_rsp.push_back(r);
  endtask

  // monitor: every strobe and ack is matched against the queues
  int n_en = 0, n_ack = 0, n_dack = 0;
  int en_cyc = 0, ack_i_cyc = 0, ack_d_cyc = 0;
  always @(negedge clk) begin
    if (mem_en_o === 1'b1) begin
      n_en++;
      en_cyc = cyc;
      if (exp_acc.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_mem_en addr %0h want none", mem_addr_o);
      end else begin
        ea = exp_acc.pop_front();
        chk("mem_we", 64'(mem_we_o), 64'(ea.we));
        chk("mem_size", 64'(mem_size_o), 64'(ea.size));
        chk("mem_addr", 64'(mem_addr_o), 64'(ea.addr));
        if (ea.we) chk("mem_wdata", 64'(mem_wdata_o), 64'(ea.wdata));
      end
    end
    if (if_ack_o === 1'b1 || d_ack_o === 1'b1) begin
      n_ack++;
      if (d_ack_o === 1'b1) begin n_dack++; ack_d_cyc = cyc; end
      else ack_i_cyc = cyc;
      chk("both_ack", 64'(if_ack_o & d_ack_o), 64'(0));
      if (exp_rsp.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack if %0b d %0b want none",
                 if_ack_o, d_ack_o);
      end else begin
        er = exp_rsp.pop_front();
        chk("ack_port", 64'(d_ack_o), 64'(er.port));
        chk("ack_rdata", d_ack_o ? 64'(d_rdata_o) : 64'(if_rdata_o),
            64'(er.rdata));
      end
    end
  end

  // memory model: mem_ready after mem_lat cycles of WAIT
  int          mem_lat = 1;
  logic        mem_auto = 1'b1;
  logic        man_rdy = 1'b0;
  logic [31:0] mem_val = '0;
  int          cnt_w = 0;
  bit          pend = 1'b0;
  int          rdy_cyc = 0;
  always @(negedge clk) begin
    if (!mem_auto) begin
      pend = 1'b0;
      mem_ready_i = man_rdy;
      mem_rdata_i = 32'hBAD0BAD0;
    end else begin
      mem_ready_i = 1'b0;
      if (pend) begin
        cnt_w--;
        if (cnt_w == 0) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = mem_val;
          pend = 1'b0;
          rdy_cyc = cyc;
        end
      end
      if (mem_en_o === 1'b1) begin
        pend = 1'b1;
        cnt_w = mem_lat;
      end
    end
  end

  // requester agents: keep req for d_rep/i_rep more accesses
  int d_rep = 0, i_rep = 0;
  task automatic tick();
    @(negedge clk);
    if (d_ack_o === 1'b1) begin
      if (d_rep > 0) d_rep--; else d_req_i = 1'b0;
    end
    if (if_ack_o === 1'b1) begin
      if (i_rep > 0) i_rep--; else if_req_i = 1'b0;
    end
  endtask

  task automatic wait_done(string name, int bound);
    int n = 0;
    while ((exp_acc.size() != 0 || exp_rsp.size() != 0 ||
            if_req_i || d_req_i) && n < bound) begin
      tick();
      n++;
    end
    if (n >= bound) begin
      checks++; errors++;
      $display("FAIL timeout_%s waited %0d want < %0d", name, n, bound);
    end
    tick();
    tick();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_mem_en"}, 64'(mem_en_o), 64'(0));
    chk({tag, "_mem_we"}, 64'(mem_we_o), 64'(0));
    chk({tag, "_mem_size"}, 64'(mem_size_o), 64'(0));
    chk({tag, "_mem_addr"}, 64'(mem_addr_o), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(mem_wdata_o), 64'(0));
    chk({tag, "_if_ack"}, 64'(if_ack_o), 64'(0));
    chk({tag, "_d_ack"}, 64'(d_ack_o), 64'(0));
    chk({tag, "_if_rdata"}, 64'(if_rdata_o), 64'(0));
    chk({tag, "_d_rdata"}, 64'(d_rdata_o), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired want finish");
    $fatal(1);
  end

  initial begin
    int t0, e0, a0, dk0, n;

    repeat (2) tick();
    chk_zero("rst");
    rst_i = 1'b0;
    tick();

    // fetch only
    mem_val = 32'h00500093;
    mem_lat = 1;
    dk0 = n_dack;
    if_addr_i = 32'h10;
    if_req_i = 1'b1;
    t0 = cyc;
    push_acc(1'b0, 3'b010, 32'h10, 32'h0);
    push_rsp(1'b0, 32'h00500093);
    wait_done("fetch", 20);
    chk("fetch_en_cyc", 64'(en_cyc - t0), 64'(1));
    chk("fetch_ack_cyc", 64'(ack_i_cyc - t0), 64'(3));
    chk("fetch_no_dack", 64'(n_dack - dk0), 64'(0));

    // simultaneous: store wins, fetch 4 cycles later
    mem_val = 32'h11111111;
    if_addr_i = 32'h14;
    d_we_i = 1'b1; d_size_i = 3'b010;
    d_addr_i = 32'h100; d_wdata_i = 32'hDEADBEEF;
    if_req_i = 1'b1; d_req_i = 1'b1;
    push_acc(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    push_acc(1'b0, 3'b010, 32'h14, 32'h0);
    push_rsp(1'b1, 32'h0);
    push_rsp(1'b0, 32'h11111111);
    wait_done("simul", 40);
    chk("simul_gap", 64'(ack_i_cyc - ack_d_cyc), 64'(4));

    // starvation: D D D D I D I
    mem_val = 32'h22222222;
    if_addr_i = 32'h20; i_rep = 1;
    d_we_i = 1'b0; d_size_i = 3'b001; d_addr_i = 32'h40; d_rep = 4;
    if_req_i = 1'b1; d_req_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (k == 4 || k == 6) begin
        push_acc(1'b0, 3'b010, 32'h20, 32'h0);
        push_rsp(1'b0, 32'h22222222);
      end else begin
        push_acc(1'b0, 3'b001, 32'h40, 32'h0);
        push_rsp(1'b1, 32'h22222222);
      end
    end
    wait_done("starve", 100);

    // slow memory load
    mem_val = 32'hCAFEF00D;
    mem_lat = 5;
    e0 = n_en;
    d_we_i = 1'b0; d_size_i = 3'b100; d_addr_i = 32'h200;
    d_req_i = 1'b1;
    push_acc(1'b0, 3'b100, 32'h200, 32'h0);
    push_rsp(1'b1, 32'hCAFEF00D);
    wait_done("slow", 40);
    chk("slow_en_count", 64'(n_en - e0), 64'(1));
    chk("slow_ack_after_rdy", 64'(ack_d_cyc - rdy_cyc), 64'(1));
    chk("slow_ack_after_en", 64'(ack_d_cyc - en_cyc), 64'(6));

    // reset while in WAIT, then a late mem_ready
    mem_auto = 1'b0;
    d_size_i = 3'b010; d_addr_i = 32'h400;
    d_req_i = 1'b1;
    push_acc(1'b0, 3'b010, 32'h400, 32'h0);
    n = 0;
    while (mem_en_o !== 1'b1 && n < 10) begin tick(); n++; end
    chk("rstmid_en_seen", 64'(mem_en_o), 64'(1));
    tick();
    e0 = n_en; a0 = n_ack;
    rst_i = 1'b1; d_req_i = 1'b0;
    tick();
    chk_zero("rstmid");
    chk("rstmid_state", 64'(dut.state_q), 64'(0));
    rst_i = 1'b0;
    man_rdy = 1'b1;
    tick();
    man_rdy = 1'b0;
    repeat (8) tick();
    chk("rstmid_no_en", 64'(n_en - e0), 64'(0));
    chk("rstmid_no_ack", 64'(n_ack - a0), 64'(0));
    mem_auto = 1'b1;
    tick();

    // field change after grant must not reach memory
    mem_val = 32'h33333333;
    mem_lat = 2;
    d_addr_i = 32'h300;
    d_req_i = 1'b1;
    push_acc(1'b0, 3'b010, 32'h300, 32'h0);
    push_rsp(1'b1, 32'h33333333);
    n = 0;
    while (mem_en_o !== 1'b1 && n < 10) begin tick(); n++; end
    d_addr_i = 32'h304;
    tick();
    chk("latched_addr", 64'(mem_addr_o), 64'(32'h300));
    wait_done("field", 30);
    chk("latched_addr_end", 64'(mem_addr_o), 64'(32'h300));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
